// File: rtl/sign_narrow.sv
`default_nettype none
// ============================================================================
// Module   : sign_narrow
// Purpose  : Narrows signed words to OUT_WIDTH bits (saturate or wrap) through
//            a 2-entry output FIFO, with overflow statistics.
// Revision : 1.0 - initial release
// ============================================================================
module sign_narrow #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  input  logic                 clr_stats,
  output logic                 ovf_sticky,
  output logic [7:0]           ovf_count
);

  localparam logic [OUT_WIDTH-1:0] c_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]                r_count;
  logic [OUT_WIDTH-1:0]      r_head_data;
  logic                      r_head_ovf;
  logic [OUT_WIDTH-1:0]      r_tail_data;
  logic                      r_tail_ovf;
  logic [7:0]                r_ovf_count;
  logic                      r_ovf_sticky;

  logic [IN_WIDTH-OUT_WIDTH:0] w_hi;
  logic                        w_ovf;
  logic [OUT_WIDTH-1:0]        w_res;
  logic                        w_push;
  logic                        w_pop;

  // The input fits exactly when the discarded bits plus the new sign bit agree.
  assign w_hi  = in_data[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_ovf = (|w_hi) && !(&w_hi);

  always_comb begin
    w_res = in_data[OUT_WIDTH-1:0];
    if (w_ovf && sat_en) begin
      w_res = in_data[IN_WIDTH-1] ? c_min : c_max;
    end
  end

  assign in_ready   = rstb && (r_count != 2'd2);
  assign out_valid  = (r_count != 2'd0);
  assign out_data   = r_head_data;
  assign out_ovf    = r_head_ovf;
  assign ovf_count  = r_ovf_count;
  assign ovf_sticky = r_ovf_sticky;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_ovf  <= 1'b0;
      r_tail_data <= '0;
      r_tail_ovf  <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_data <= w_res;
            r_head_ovf  <= w_ovf;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_data <= w_res;
            r_head_ovf  <= w_ovf;
          end else if (w_push) begin
            r_tail_data <= w_res;
            r_tail_ovf  <= w_ovf;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count     <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the tail entry.
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_ovf  <= r_tail_ovf;
            r_count     <= 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb || clr_stats) begin
      r_ovf_count  <= 8'd0;
      r_ovf_sticky <= 1'b0;
    end else if (w_push && w_ovf) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != 8'hFF) begin
        r_ovf_count <= r_ovf_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sign_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_narrow
// Purpose  : Self-checking bench for sign_narrow against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_narrow;

  localparam int c_iw  = 32;
  localparam int c_ow  = 5;
  localparam int c_max = (1 << (c_ow - 1)) - 1;
  localparam int c_min = -(1 << (c_ow - 1));

  logic            clk = 1'b0;
  logic            rstb;
  logic            in_valid;
  logic            in_ready;
  logic [c_iw-1:0] in_data;
  logic            sat_en;
  logic            out_valid;
  logic            out_ready;
  logic [c_ow-1:0] out_data;
  logic            out_ovf;
  logic            clr_stats;
  logic            ovf_sticky;
  logic [7:0]      ovf_count;

  typedef struct {
    logic [c_ow-1:0] d;
    logic            o;
  } ent_t;

  ent_t q[$];
  int   m_count;
  bit   m_sticky;
  int   n_checks;
  int   n_fail;

  sign_narrow #(.IN_WIDTH(c_iw), .OUT_WIDTH(c_ow)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .clr_stats  (clr_stats),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: interpret the word as an integer and clamp/truncate it.
  function automatic ent_t ref_narrow(input logic [c_iw-1:0] x, input logic sat);
    ent_t e;
    int   v;
    v   = $signed(x);
    e.o = (v > c_max) || (v < c_min);
    if (e.o && sat) v = (v > 0) ? c_max : c_min;
    e.d = v[c_ow-1:0];
    return e;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, (rstb && q.size() < 2) ? 1 : 0);
    chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
    chk("ovf_count", ovf_count, m_count);
    chk("ovf_sticky", ovf_sticky, m_sticky);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ovf", out_ovf, q[0].o);
    end
  endtask

  // One clock: predict transfers from current inputs, advance, compare.
  task automatic cycle();
    bit   push;
    bit   pop;
    ent_t e;
    push = in_valid && rstb && (q.size() < 2);
    pop  = rstb && (q.size() > 0) && out_ready;
    e    = ref_narrow(in_data, sat_en);
    @(posedge clk);
    if (!rstb) begin
      q.delete();
      m_count  = 0;
      m_sticky = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (clr_stats) begin
        m_count  = 0;
        m_sticky = 0;
      end else if (push && e.o) begin
        m_sticky = 1;
        if (m_count < 255) m_count++;
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [c_iw-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return c_iw'($signed($urandom_range(0, 31)) - 16);
      1:       return c_iw'($signed($urandom_range(0, 15)) - 24 + (($urandom_range(0, 1) != 0) ? 32 : 0));
      2:       return $urandom();
      default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endcase
  endfunction

  logic [31:0] v35_in  [4];
  logic [4:0]  v35_d   [4];
  logic        v35_o   [4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_count   = 0;
    m_sticky  = 0;
    rstb      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sat_en    = 1'b1;
    out_ready = 1'b1;
    clr_stats = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rstb = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Saturating vectors with one-cycle latency
    v35_in = '{32'h0000_000F, 32'h0000_0010, 32'hFFFF_FFF0, 32'h8000_0000};
    v35_d  = '{5'h0F, 5'h0F, 5'h10, 5'h10};
    v35_o  = '{1'b0, 1'b1, 1'b0, 1'b1};
    sat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v35_in[i];
      cycle();
      chk("sat_vec_valid", out_valid, 1);
      chk("sat_vec_data", out_data, v35_d[i]);
      chk("sat_vec_ovf", out_ovf, v35_o[i]);
    end
    in_valid = 1'b0;
    cycle();

    // Wrap mode
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    sat_en    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0031;
    cycle();
    in_valid  = 1'b0;
    chk("wrap_data", out_data, 5'h11);
    chk("wrap_ovf", out_ovf, 1);
    chk("wrap_count", ovf_count, 1);
    cycle();

    // Back-pressure: A, B accepted, C stalls until the first pop
    out_ready = 1'b0;
    sat_en    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0003;
    cycle();
    in_data   = 32'h0000_0100;
    cycle();
    chk("full_in_ready", in_ready, 0);
    in_data   = 32'hFFFF_FFFB;
    cycle();
    chk("full_hold_ready", in_ready, 0);
    chk("full_head_data", out_data, 5'h03);
    out_ready = 1'b1;
    cycle();
    chk("pop_in_ready", in_ready, 1);
    chk("pop_head_data", out_data, 5'h0F);
    cycle();
    in_valid = 1'b0;
    chk("pop_c_data", out_data, 5'h1B);
    cycle();
    chk("drain_valid", out_valid, 0);

    // Counter saturation, then clear beating a coincident overflow
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 32'h0000_1000 + i;
      sat_en  = $urandom_range(0, 1);
      cycle();
    end
    chk("sat_count", ovf_count, 255);
    chk("sat_sticky", ovf_sticky, 1);
    clr_stats = 1'b1;
    in_data   = 32'hF000_0000;
    cycle();
    clr_stats = 1'b0;
    in_valid  = 1'b0;
    chk("clr_count", ovf_count, 0);
    chk("clr_sticky", ovf_sticky, 0);
    cycle();

    // Reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0005;
    cycle();
    cycle();
    in_valid  = 1'b0;
    chk("pre_rst_ready", in_ready, 0);
    rstb = 1'b0;
    cycle();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    rstb = 1'b1;
    #1;
    chk("mid_rel_ready", in_ready, 1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_word();
      sat_en    = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 199) == 0);
      rstb      = ($urandom_range(0, 999) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning the signed input word width.
REQ-002 SHALL have parameter OUT_WIDTH, default 5, meaning the signed output field width; legal range is 2 <= OUT_WIDTH < IN_WIDTH.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstb  input  1  meaning a synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_data is offered.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts this cycle.
REQ-007 SHALL have port in_data  input  IN_WIDTH  meaning the two's-complement value to narrow.
REQ-008 SHALL have port sat_en  input  1  meaning 1 = saturate and 0 = wrap, sampled with each accepted transfer.
REQ-009 SHALL have port out_valid  output  1  meaning out_data and out_ovf are valid.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer accepts this cycle.
REQ-011 SHALL have port out_data  output  OUT_WIDTH  meaning the narrowed result.
REQ-012 SHALL have port out_ovf  output  1  meaning the current out_data came from an unrepresentable input.
REQ-013 SHALL have port clr_stats  input  1  meaning a synchronous clear of the statistics.
REQ-014 SHALL have port ovf_sticky  output  1  meaning at least one overflow has occurred since the last reset or clear.
REQ-015 SHALL have port ovf_count  output  8  meaning the number of overflowed accepted transfers, saturating.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 Results SHALL be held in a 2-entry FIFO; in_ready SHALL be 1 exactly when the stored entry count is below 2, decoded from registers only, with no combinational path from out_ready or in_valid.
REQ-018 out_valid SHALL be 1 exactly when the entry count is at least 1; out_data and out_ovf SHALL show the oldest entry and stay stable while out_valid && !out_ready.
REQ-019 Latency SHALL be 1 cycle: an input accepted into an empty FIFO appears on out_valid/out_data on the following cycle.
REQ-020 When the FIFO holds 1 entry, a simultaneous input and output transfer SHALL leave the count at 1 with the new entry at the head.
REQ-021 When the FIFO is full, no input transfer SHALL occur; an output transfer SHALL drop the count to 1 and raise in_ready the next cycle.
REQ-022 Results SHALL leave in acceptance order; no entry SHALL be lost or duplicated.
REQ-023 Overflow SHALL be detected when in_data[IN_WIDTH-1:OUT_WIDTH-1] is neither all zeros nor all ones.
REQ-024 Without overflow, the result SHALL be in_data[OUT_WIDTH-1:0] regardless of sat_en.
REQ-025 On overflow with sat_en = 1, the result SHALL be the maximum positive value (0 followed by ones) if in_data[IN_WIDTH-1] = 0, otherwise the minimum value (1 followed by zeros).
REQ-026 On overflow with sat_en = 0, the result SHALL be in_data[OUT_WIDTH-1:0].
REQ-027 out_ovf SHALL be stored per entry and SHALL be set for every overflowed input in either mode.
REQ-028 ovf_count SHALL increment by 1 on each accepted overflowed input and SHALL hold at 255 rather than wrap.
REQ-029 ovf_sticky SHALL set on the cycle after the first accepted overflowed input.
REQ-030 clr_stats SHALL zero ovf_count and ovf_sticky on the next edge; an overflow accepted in the same cycle SHALL be discarded (clear wins).
REQ-031 clr_stats SHALL NOT affect FIFO contents or handshakes.

Reset
REQ-032 With rstb = 0 at a rising edge, the FIFO SHALL empty and out_valid, out_ovf, ovf_sticky and ovf_count SHALL all go to 0.
REQ-033 While rstb = 0, in_ready SHALL be 0; in_ready SHALL be 1 on the first cycle after rstb returns high.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries with no output transfer; out_data after reset SHALL be 0.

Verification
REQ-035 Defaults, sat_en = 1, out_ready = 1, inputs 0x0000000F, 0x00000010, 0xFFFFFFF0, 0x80000000 SHALL produce out_data 0x0F/0, 0x0F/1, 0x10/0, 0x10/1 (data/ovf), each 1 cycle after acceptance.
REQ-036 sat_en = 0, input 0x00000031 SHALL produce out_data 0x11 with out_ovf = 1 and ovf_count = 1.
REQ-037 out_ready = 0 and three back-to-back inputs A, B, C SHALL give in_ready = 0 after 2 accepts; raising out_ready SHALL yield A, B, C in order with in_ready returning 1 cycle after the first pop.
REQ-038 300 consecutive overflowed inputs SHALL leave ovf_count at 255 and ovf_sticky at 1; clr_stats coincident with a further overflow SHALL leave both at 0.
REQ-039 Pulsing rstb low while the FIFO holds 2 entries SHALL give out_valid = 0 and count = 0 on the next cycle and in_ready = 1 after release.
REQ-040 Random valid/ready stimulus over 10k cycles, checked against a reference model, SHALL show no mismatch, loss or reorder.
